ysyx_22041071_rd_arb: RTL and testbench



---
 rtl/ysyx_22041071_rd_arb.sv | 169 ++++++++++++++++
 tb/tb_ysyx_22041071_rd_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_rd_arb.sv
// Round-robin read arbiter between IFU refill bursts and LSU loads, with beat
// counting, response routing and LSU byte alignment / sign extension.
module ysyx_22041071_rd_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic [LEN_W-1:0]  if_req_len,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_last,
    output logic [1:0]        if_rsp_resp,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [1:0]        ls_req_size,
    input  logic              ls_req_signed,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic [1:0]        ls_rsp_resp,
    output logic              rd_ar_valid,
    output logic [ID_W-1:0]   rd_id,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    output logic [1:0]        rd_size,
    input  logic              rd_ar_ready,
    input  logic              rd_r_valid,
    input  logic [DATA_W-1:0] rd_r_data,
    input  logic [1:0]        rd_r_resp
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    state_t           state;
    logic             last_grant;
    logic [LEN_W-1:0] beat_cnt;
    logic             ls_signed_q;
    logic [2:0]       ls_off_q;
    logic             grant_ls;
    logic             grant_if;
    logic             beat;
    logic             final_beat;

    // Shift the addressed bytes down, keep 1/2/4/8 bytes, then extend.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [DATA_W-1:0] raw,
        input logic [2:0]        off,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0]        sh;
        logic signed [DATA_W-1:0] sx;
        logic [DATA_W-1:0]        zx;
        sh = raw >> {off, 3'b000};
        case (size)
            2'b00: begin
                sx = {{(DATA_W-8){sh[7]}}, sh[7:0]};
                zx = {{(DATA_W-8){1'b0}}, sh[7:0]};
            end
            2'b01: begin
                sx = {{(DATA_W-16){sh[15]}}, sh[15:0]};
                zx = {{(DATA_W-16){1'b0}}, sh[15:0]};
            end
            2'b10: begin
                sx = {{(DATA_W-32){sh[31]}}, sh[31:0]};
                zx = {{(DATA_W-32){1'b0}}, sh[31:0]};
            end
            default: begin
                sx = sh;
                zx = sh;
            end
        endcase
        return sgn ? sx : zx;
    endfunction

    // On a tie the requester not served last wins; reset leaves IFU as last.
    assign grant_ls     = ls_req_valid & (~if_req_valid | (last_grant == GRANT_IF));
    assign grant_if     = if_req_valid & ~grant_ls;
    assign if_req_ready = (state == IDLE) & grant_if;
    assign ls_req_ready = (state == IDLE) & grant_ls;
    assign beat         = (state == WAIT) & rd_r_valid;
    assign final_beat   = beat & (beat_cnt == rd_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= GRANT_IF;
            beat_cnt     <= '0;
            ls_signed_q  <= 1'b0;
            ls_off_q     <= 3'b000;
            rd_ar_valid  <= 1'b0;
            rd_id        <= '0;
            rd_addr      <= '0;
            rd_len       <= '0;
            rd_size      <= 2'b00;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_last  <= 1'b0;
            if_rsp_resp  <= 2'b00;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            ls_rsp_resp  <= 2'b00;
        end else begin
            if_rsp_valid <= 1'b0;
            if_rsp_last  <= 1'b0;
            ls_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_ready) begin
                        rd_id       <= ID_W'(0);
                        rd_addr     <= if_req_addr;
                        rd_len      <= if_req_len;
                        rd_size     <= 2'b11;
                        last_grant  <= GRANT_IF;
                        rd_ar_valid <= 1'b1;
                        state       <= ISSUE;
                    end else if (ls_req_ready) begin
                        rd_id       <= ID_W'(1);
                        rd_addr     <= ls_req_addr;
                        rd_len      <= '0;
                        rd_size     <= ls_req_size;
                        ls_signed_q <= ls_req_signed;
                        ls_off_q    <= ls_req_addr[2:0];
                        last_grant  <= GRANT_LS;
                        rd_ar_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_ar_ready) begin
                        rd_ar_valid <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_r_valid) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (final_beat) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Beats are routed by the held ID; responses are never back-pressured.
            if (beat) begin
                if (rd_id == ID_W'(0)) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= rd_r_data;
                    if_rsp_resp  <= rd_r_resp;
                    if_rsp_last  <= final_beat;
                end else begin
                    ls_rsp_valid <= 1'b1;
                    ls_rsp_data  <= load_ext(rd_r_data, ls_off_q, rd_size, ls_signed_q);
                    ls_rsp_resp  <= rd_r_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_rd_arb.sv
// Directed plus randomized bench for the read arbiter; the bench acts as the
// read master and predicts every response from the load rules.
module tb_ysyx_22041071_rd_arb;

    logic        clk;
    logic        reset;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic [7:0]  if_req_len;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        if_rsp_last;
    logic [1:0]  if_rsp_resp;
    logic        ls_req_valid;
    logic [63:0] ls_req_addr;
    logic [1:0]  ls_req_size;
    logic        ls_req_signed;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;
    logic [1:0]  ls_rsp_resp;
    logic        rd_ar_valid;
    logic [3:0]  rd_id;
    logic [63:0] rd_addr;
    logic [7:0]  rd_len;
    logic [1:0]  rd_size;
    logic        rd_ar_ready;
    logic        rd_r_valid;
    logic [63:0] rd_r_data;
    logic [1:0]  rd_r_resp;

    int errs = 0;
    int checks = 0;
    int if_pulses = 0;
    int ls_pulses = 0;
    int ar_hs = 0;
    int exp_if = 0;
    int exp_ls = 0;
    int exp_ar = 0;

    ysyx_22041071_rd_arb dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_len(if_req_len),
        .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_last(if_rsp_last),
        .if_rsp_resp(if_rsp_resp),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_size(ls_req_size),
        .ls_req_signed(ls_req_signed), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_resp(ls_rsp_resp),
        .rd_ar_valid(rd_ar_valid), .rd_id(rd_id), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_size(rd_size), .rd_ar_ready(rd_ar_ready),
        .rd_r_valid(rd_r_valid), .rd_r_data(rd_r_data), .rd_r_resp(rd_r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_rsp_valid) if_pulses++;
        if (ls_rsp_valid) ls_pulses++;
    end

    always @(posedge clk) begin
        if (!reset && rd_ar_valid && rd_ar_ready) ar_hs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
        end
    endtask

    // Reference load result: pick 2^size bytes starting at the byte offset.
    function automatic logic [63:0] model_load(input logic [63:0] d, input int off, input int sz, input bit sgn);
        int          nbits;
        logic [63:0] mask;
        logic [63:0] v;
        nbits = 8 * (1 << sz);
        mask  = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        v     = (d >> (off * 8)) & mask;
        if (sgn && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic lsu_load(input logic [63:0] addr, input logic [1:0] size, input logic sgn,
                            input logic [63:0] data, input logic [1:0] resp,
                            input int ar_delay, input int lat, input logic [63:0] expv,
                            input string tag);
        int n;
        ls_req_valid  = 1'b1;
        ls_req_addr   = addr;
        ls_req_size   = size;
        ls_req_signed = sgn;
        #1;
        n = 0;
        while (!ls_req_ready && n < 20) begin
            tick();
            n++;
        end
        check(tag, "ls_req_ready", ls_req_ready, 1);
        tick();
        ls_req_valid = 1'b0;
        for (int i = 0; i <= ar_delay; i++) begin
            check(tag, "rd_ar_valid", rd_ar_valid, 1);
            check(tag, "rd_addr", rd_addr, addr);
            check(tag, "rd_len", rd_len, 0);
            check(tag, "rd_id", rd_id, 1);
            check(tag, "rd_size", rd_size, size);
            rd_ar_ready = (i == ar_delay);
            tick();
        end
        rd_ar_ready = 1'b0;
        exp_ar++;
        check(tag, "ar_drop", rd_ar_valid, 0);
        repeat (lat) tick();
        rd_r_valid = 1'b1;
        rd_r_data  = data;
        rd_r_resp  = resp;
        tick();
        rd_r_valid = 1'b0;
        check(tag, "ls_rsp_valid", ls_rsp_valid, 1);
        check(tag, "ls_rsp_data", ls_rsp_data, expv);
        check(tag, "ls_rsp_resp", ls_rsp_resp, resp);
        check(tag, "if_quiet", if_rsp_valid, 0);
        exp_ls++;
    endtask

    task automatic ifu_burst(input logic [63:0] addr, input int len, input int ar_delay,
                             input bit rand_resp, input int abort_after, input string tag);
        int          n;
        logic [63:0] d;
        logic [1:0]  r;
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        if_req_len   = 8'(len);
        #1;
        n = 0;
        while (!if_req_ready && n < 20) begin
            tick();
            n++;
        end
        check(tag, "if_req_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        for (int i = 0; i <= ar_delay; i++) begin
            check(tag, "rd_ar_valid", rd_ar_valid, 1);
            check(tag, "rd_addr", rd_addr, addr);
            check(tag, "rd_len", rd_len, len);
            check(tag, "rd_id", rd_id, 0);
            check(tag, "rd_size", rd_size, 2'b11);
            rd_ar_ready = (i == ar_delay);
            tick();
        end
        rd_ar_ready = 1'b0;
        exp_ar++;
        for (int b = 0; b <= len; b++) begin
            check(tag, "no_ar_in_wait", rd_ar_valid, 0);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check(tag, "no_ar_in_gap", rd_ar_valid, 0);
            end
            d = {$urandom, $urandom};
            r = rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
            rd_r_valid = 1'b1;
            rd_r_data  = d;
            rd_r_resp  = r;
            tick();
            rd_r_valid = 1'b0;
            check(tag, "if_rsp_valid", if_rsp_valid, 1);
            check(tag, "if_rsp_data", if_rsp_data, d);
            check(tag, "if_rsp_last", if_rsp_last, (b == len));
            check(tag, "if_rsp_resp", if_rsp_resp, r);
            check(tag, "ls_quiet", ls_rsp_valid, 0);
            exp_if++;
            if (b == abort_after) return;
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] a;
        logic [1:0]  sz;
        logic        sg;
        logic [1:0]  rs;
        d = 64'h8877_6655_4433_2211;
        reset = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0; if_req_len = '0;
        ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_size = '0; ls_req_signed = 1'b0;
        rd_ar_ready = 1'b0; rd_r_valid = 1'b0; rd_r_data = '0; rd_r_resp = '0;
        tick();
        tick();
        check("reset", "rd_ar_valid", rd_ar_valid, 0);
        check("reset", "rd_addr", rd_addr, 0);
        check("reset", "if_rsp_valid", if_rsp_valid, 0);
        check("reset", "ls_rsp_data", ls_rsp_data, 0);
        check("reset", "if_req_ready", if_req_ready, 0);
        reset = 1'b0;
        tick();

        // Tie right after reset: LSU first, then IFU in the first idle cycle.
        if_req_valid = 1'b1; if_req_addr = 64'h8000_1000; if_req_len = 8'd3;
        ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0003; ls_req_size = 2'b00; ls_req_signed = 1'b1;
        #1;
        check("tie1", "ls_req_ready", ls_req_ready, 1);
        check("tie1", "if_req_ready", if_req_ready, 0);
        lsu_load(64'h8000_0003, 2'b00, 1'b1, d, 2'b00, 0, 1, 64'h44, "lb_off3");
        check("tie1", "if_after_ls", if_req_ready, 1);
        ifu_burst(64'h8000_1000, 3, 0, 1'b0, -1, "ifu_len3");

        // Both pending again: IFU was served last, so LSU wins.
        if_req_valid = 1'b1; if_req_addr = 64'h8000_2000; if_req_len = 8'd0;
        ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0007; ls_req_size = 2'b00; ls_req_signed = 1'b1;
        #1;
        check("tie2", "ls_req_ready", ls_req_ready, 1);
        check("tie2", "if_req_ready", if_req_ready, 0);
        lsu_load(64'h8000_0007, 2'b00, 1'b1, d, 2'b00, 0, 0, 64'hFFFF_FFFF_FFFF_FF88, "lb_off7");
        ifu_burst(64'h8000_2000, 0, 1, 1'b0, -1, "ifu_len0");

        lsu_load(64'h8000_0007, 2'b00, 1'b0, d, 2'b00, 0, 0, 64'h88, "lbu_off7");
        lsu_load(64'h8000_0004, 2'b01, 1'b1, d, 2'b00, 0, 2, 64'h6655, "lh_off4");
        lsu_load(64'h8000_0004, 2'b10, 1'b1, d, 2'b10, 0, 0, 64'hFFFF_FFFF_8877_6655, "lw_off4_err");
        lsu_load(64'h8000_0010, 2'b11, 1'b0, d, 2'b00, 3, 1, d, "ld_arbp");

        // Reset in the middle of a burst, after its first beat.
        ifu_burst(64'h8000_3000, 3, 0, 1'b0, 0, "rst_burst");
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_mid", "if_rsp_valid", if_rsp_valid, 0);
        check("rst_mid", "if_rsp_data", if_rsp_data, 0);
        check("rst_mid", "rd_ar_valid", rd_ar_valid, 0);
        check("rst_mid", "rd_addr", rd_addr, 0);
        check("rst_mid", "rd_len", rd_len, 0);
        check("rst_mid", "rd_id", rd_id, 0);
        tick();
        tick();
        reset = 1'b0;
        rd_r_valid = 1'b1;
        rd_r_data  = 64'hDEAD_BEEF_0000_0001;
        tick();
        tick();
        rd_r_valid = 1'b0;
        check("rst_mid", "stray_if_rsp", if_rsp_valid, 0);
        check("rst_mid", "stray_ls_rsp", ls_rsp_valid, 0);
        lsu_load(64'h8000_0002, 2'b01, 1'b0, d, 2'b00, 0, 0, 64'h4433, "post_rst");

        // Randomized traffic against the reference load model.
        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                a  = {$urandom, $urandom};
                sz = 2'($urandom_range(0, 3));
                sg = 1'($urandom_range(0, 1));
                rs = 2'($urandom_range(0, 3));
                d  = {$urandom, $urandom};
                lsu_load(a, sz, sg, d, rs, $urandom_range(0, 2), $urandom_range(0, 2),
                         model_load(d, int'(a[2:0]), int'(sz), sg), "rnd_ls");
            end else begin
                a = {$urandom, $urandom[31:3], 3'b000};
                ifu_burst(a, $urandom_range(0, 4), $urandom_range(0, 2), 1'b1, -1, "rnd_if");
            end
        end

        tick();
        tick();
        tick();
        check("totals", "if_pulses", 64'(if_pulses), 64'(exp_if));
        check("totals", "ls_pulses", 64'(ls_pulses), 64'(exp_ls));
        check("totals", "ar_handshakes", 64'(ar_hs), 64'(exp_ar));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
